regfile_port_ctrl: RTL and testbench

- Owns both write ports and the srcB read port of the 15-entry 64-bit Y86 register file; sits between the W pipeline register / decode stage and the regfile.
- After reset, sequences a hardware clear of all registers, with %rsp loaded to STACK_INIT.
- In normal run it passes pipeline writeback through, and grants a single-request host/debug port read or write access by stealing idle port slots or forcing a one-cycle pipeline stall.

---
 rtl/regfile_port_ctrl_pkg.sv | 30 +++
 rtl/regfile_port_ctrl_clear_seq.sv | 39 +++
 rtl/regfile_port_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regfile_port_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_port_ctrl_pkg.sv
// Shared definitions for the Y86 register-file port controller: register
// indices, clear-sequence constants and the controller state encoding.
package regfile_port_ctrl_pkg;

    localparam logic [3:0] RAX   = 4'h0;
    localparam logic [3:0] RCX   = 4'h1;
    localparam logic [3:0] RDX   = 4'h2;
    localparam logic [3:0] RBX   = 4'h3;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RBP   = 4'h5;
    localparam logic [3:0] RSI   = 4'h6;
    localparam logic [3:0] RDI   = 4'h7;
    localparam logic [3:0] R8    = 4'h8;
    localparam logic [3:0] R9    = 4'h9;
    localparam logic [3:0] R10   = 4'hA;
    localparam logic [3:0] R11   = 4'hB;
    localparam logic [3:0] R12   = 4'hC;
    localparam logic [3:0] R13   = 4'hD;
    localparam logic [3:0] R14   = 4'hE;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [63:0] STACK_INIT_DEFAULT = 64'h0000_0000_0000_0200;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_port_ctrl_clear_seq.sv
// Post-reset clear sequencer: walks the register index and supplies the
// value to be written at each step (%rsp gets the stack base, others zero).
module regfile_clear_seq
    import regfile_port_ctrl_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = STACK_INIT_DEFAULT,
    parameter int          NREGS      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [3:0]  idx_o,
    output logic [63:0] init_val_o,
    output logic        last_o
);

    logic [3:0] idx_q;
    logic [3:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (en_i) begin
            idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 4'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o      = idx_q;
    assign init_val_o = (idx_q == RSP) ? STACK_INIT : 64'd0;
    assign last_o     = (idx_q == 4'(NREGS - 1));

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file write/srcB port owner: runs the post-reset clear, passes
// pipeline writeback through, and slots single host accesses into idle ports.
module regfile_port_ctrl
    import regfile_port_ctrl_pkg::*;
#(
    parameter logic [63:0] STACK_INIT   = STACK_INIT_DEFAULT,
    parameter int          STARVE_LIMIT = 4,
    parameter int          NREGS        = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [63:0] rf_valB,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [3:0]  host_reg,
    input  logic [63:0] host_wdata,
    output logic [3:0]  rf_dstE,
    output logic [63:0] rf_valE,
    output logic [3:0]  rf_dstM,
    output logic [63:0] rf_valM,
    output logic [3:0]  rf_srcA,
    output logic [3:0]  rf_srcB,
    output logic        pipe_stall,
    output logic        init_done,
    output logic        host_ack,
    output logic [63:0] host_rdata,
    output logic        host_err
);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        host_ack_q, host_ack_d;
    logic [63:0] host_rdata_q, host_rdata_d;
    logic        host_err_q, host_err_d;
    logic        init_done_q, init_done_d;

    logic [3:0]  clr_idx;
    logic [63:0] clr_val;
    logic        clr_last;
    logic        access;

    regfile_clear_seq #(
        .STACK_INIT (STACK_INIT),
        .NREGS      (NREGS)
    ) u_clear_seq (
        .clk        (clock),
        .rst_n      (reset),
        .en_i       (state_q == ST_CLEAR),
        .idx_o      (clr_idx),
        .init_val_o (clr_val),
        .last_o     (clr_last)
    );

    assign rf_srcA = d_srcA;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        host_err_d   = host_err_q;
        init_done_d  = init_done_q;
        access       = 1'b0;
        rf_dstE      = W_dstE;
        rf_valE      = W_valE;
        rf_dstM      = W_dstM;
        rf_valM      = W_valM;
        rf_srcB      = d_srcB;
        pipe_stall   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                rf_dstE    = clr_idx;
                rf_valE    = clr_val;
                rf_dstM    = RNONE;
                pipe_stall = 1'b1;
                if (clr_last) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                starve_d = 4'd0;
                if (host_req) begin
                    if (host_reg == RNONE) begin
                        host_ack_d = 1'b1;
                        host_err_d = 1'b1;
                        state_d    = ST_ACK;
                    end else if (host_we && W_dstM == RNONE && host_reg != W_dstE) begin
                        rf_dstM = host_reg;
                        rf_valM = host_wdata;
                        access  = 1'b1;
                    end else if (host_we && W_dstE == RNONE && host_reg != W_dstM) begin
                        rf_dstE = host_reg;
                        rf_valE = host_wdata;
                        access  = 1'b1;
                    end else if (!host_we && host_reg != W_dstE && host_reg != W_dstM) begin
                        rf_srcB      = host_reg;
                        pipe_stall   = 1'b1;
                        host_rdata_d = rf_valB;
                        access       = 1'b1;
                    end else if (starve_q == 4'(STARVE_LIMIT)) begin
                        // Forced slot: freeze the pipeline and drop its writes;
                        // the held W register replays them next cycle.
                        pipe_stall = 1'b1;
                        rf_dstE    = RNONE;
                        rf_dstM    = RNONE;
                        access     = 1'b1;
                        if (host_we) begin
                            rf_dstM = host_reg;
                            rf_valM = host_wdata;
                        end else begin
                            rf_srcB      = host_reg;
                            host_rdata_d = rf_valB;
                        end
                    end else begin
                        starve_d = starve_q + 4'd1;
                    end
                    if (access) begin
                        host_ack_d = 1'b1;
                        host_err_d = 1'b0;
                        state_d    = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // While reset is held, keep the pipeline frozen and the regfile untouched.
        if (!reset) begin
            pipe_stall = 1'b1;
            rf_dstE    = RNONE;
            rf_dstM    = RNONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_CLEAR;
            starve_q     <= 4'd0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 64'd0;
            host_err_q   <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            host_err_q   <= host_err_d;
            init_done_q  <= init_done_d;
        end
    end

    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign host_err   = host_err_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural 16-entry regfile model, directed
// host/pipeline vectors, and an ack scoreboard fed by the stimulus thread.
module tb_regfile_port_ctrl;

  logic        clock;
  logic        reset;
  logic [3:0]  W_dstE, W_dstM, d_srcA, d_srcB, host_reg;
  logic [63:0] W_valE, W_valM, rf_valB, host_wdata;
  logic        host_req, host_we;
  logic [3:0]  rf_dstE, rf_dstM, rf_srcA, rf_srcB;
  logic [63:0] rf_valE, rf_valM, host_rdata;
  logic        pipe_stall, init_done, host_ack, host_err;

  logic [63:0] regs [0:15];

  // {check_rdata, err, rdata}
  logic [65:0] exp_q[$];
  int tests;
  int fails;

  regfile_port_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .W_dstE     (W_dstE),
    .W_valE     (W_valE),
    .W_dstM     (W_dstM),
    .W_valM     (W_valM),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .rf_valB    (rf_valB),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_reg   (host_reg),
    .host_wdata (host_wdata),
    .rf_dstE    (rf_dstE),
    .rf_valE    (rf_valE),
    .rf_dstM    (rf_dstM),
    .rf_valM    (rf_valM),
    .rf_srcA    (rf_srcA),
    .rf_srcB    (rf_srcB),
    .pipe_stall (pipe_stall),
    .init_done  (init_done),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_err   (host_err)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // regfile model: M port wins on a same-index double write
  always @(posedge clock) begin
    if (rf_dstE != 4'hF) regs[rf_dstE] <= rf_valE;
    if (rf_dstM != 4'hF) regs[rf_dstM] <= rf_valM;
  end
  assign rf_valB = (rf_srcB == 4'hF) ? 64'd0 : regs[rf_srcB];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic w_idle();
    W_dstE = 4'hF; W_valE = 64'd0;
    W_dstM = 4'hF; W_valM = 64'd0;
  endtask

  task automatic host_issue(input logic we, input logic [3:0] r, input logic [63:0] wd);
    host_req = 1'b1; host_we = we; host_reg = r; host_wdata = wd;
  endtask

  task automatic host_drop();
    host_req = 1'b0; host_we = 1'b0; host_reg = 4'h0; host_wdata = 64'd0;
  endtask

  task automatic check_clear_walk();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("clr_dstE_%0d", i), {60'd0, rf_dstE}, 64'(i));
      check($sformatf("clr_valE_%0d", i), rf_valE, (i == 4) ? 64'h200 : 64'd0);
      check($sformatf("clr_stall_%0d", i), {63'd0, pipe_stall}, 64'd1);
      check($sformatf("clr_dstM_%0d", i), {60'd0, rf_dstM}, 64'hF);
      check($sformatf("clr_done_%0d", i), {63'd0, init_done}, 64'd0);
      step();
    end
    check("clr_done_after", {63'd0, init_done}, 64'd1);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset && host_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {63'd0, host_ack}, 64'd0);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        check("ack_err", {63'd0, host_err}, {63'd0, e[64]});
        if (e[65]) check("ack_rdata", host_rdata, e[63:0]);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 16; i++) regs[i] = 64'hAAAA_AAAA_AAAA_AAAA;
    reset = 1'b1;
    w_idle();
    d_srcA = 4'h7; d_srcB = 4'h6;
    host_drop();
    #2 reset = 1'b0;
    #20;
    check("rst_stall", {63'd0, pipe_stall}, 64'd1);
    check("rst_dstE", {60'd0, rf_dstE}, 64'hF);
    check("rst_dstM", {60'd0, rf_dstM}, 64'hF);
    check("rst_done", {63'd0, init_done}, 64'd0);
    check("rst_ack", {63'd0, host_ack}, 64'd0);
    check("rst_rdata", host_rdata, 64'd0);

    // release away from the active edge, then walk the clear
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_clear_walk();
    for (int i = 0; i < 15; i++)
      check($sformatf("clr_reg_%0d", i), regs[i], (i == 4) ? 64'h200 : 64'd0);
    check("run_stall", {63'd0, pipe_stall}, 64'd0);
    check("run_srcA", {60'd0, rf_srcA}, 64'h7);
    check("run_srcB", {60'd0, rf_srcB}, 64'h6);

    // host write stealing the idle M port
    W_dstE = 4'h0; W_valE = 64'h11;
    host_issue(1'b1, 4'h3, 64'hDEAD);
    exp_q.push_back({1'b0, 1'b0, 64'd0});
    #1;
    check("wr_dstM", {60'd0, rf_dstM}, 64'h3);
    check("wr_valM", rf_valM, 64'hDEAD);
    check("wr_dstE", {60'd0, rf_dstE}, 64'h0);
    check("wr_valE", rf_valE, 64'h11);
    check("wr_stall", {63'd0, pipe_stall}, 64'd0);
    step();
    host_drop();
    w_idle();
    #1;
    check("wr_ack", {63'd0, host_ack}, 64'd1);
    check("wr_ack_stall", {63'd0, pipe_stall}, 64'd0);
    step();
    check("wr_ack_gone", {63'd0, host_ack}, 64'd0);
    check("wr_rbx", regs[3], 64'hDEAD);
    check("wr_rax", regs[0], 64'h11);

    // both ports busy: four blocked cycles then a forced slot
    W_dstE = 4'h1; W_valE = 64'h111;
    W_dstM = 4'h2; W_valM = 64'h222;
    host_issue(1'b1, 4'h5, 64'h55);
    exp_q.push_back({1'b0, 1'b0, 64'd0});
    #1;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("blk_stall_%0d", c), {63'd0, pipe_stall}, 64'd0);
      check($sformatf("blk_dstE_%0d", c), {60'd0, rf_dstE}, 64'h1);
      check($sformatf("blk_dstM_%0d", c), {60'd0, rf_dstM}, 64'h2);
      step();
      check($sformatf("blk_ack_%0d", c), {63'd0, host_ack}, 64'd0);
    end
    check("frc_stall", {63'd0, pipe_stall}, 64'd1);
    check("frc_dstE", {60'd0, rf_dstE}, 64'hF);
    check("frc_dstM", {60'd0, rf_dstM}, 64'h5);
    check("frc_valM", rf_valM, 64'h55);
    step();
    host_drop();
    #1;
    check("frc_ack", {63'd0, host_ack}, 64'd1);
    check("frc_replay_dstE", {60'd0, rf_dstE}, 64'h1);
    check("frc_replay_dstM", {60'd0, rf_dstM}, 64'h2);
    step();
    w_idle();
    check("frc_rbp", regs[5], 64'h55);
    check("frc_rcx", regs[1], 64'h111);
    check("frc_rdx", regs[2], 64'h222);

    // host read of %rsp with W idle
    host_issue(1'b0, 4'h4, 64'd0);
    exp_q.push_back({1'b1, 1'b0, 64'h200});
    #1;
    check("rd_srcB", {60'd0, rf_srcB}, 64'h4);
    check("rd_stall", {63'd0, pipe_stall}, 64'd1);
    step();
    host_drop();
    #1;
    check("rd_ack", {63'd0, host_ack}, 64'd1);
    check("rd_ack_stall", {63'd0, pipe_stall}, 64'd0);
    step();

    // host read blocked by a pipeline write to the same register
    W_dstE = 4'h3; W_valE = 64'h333;
    host_issue(1'b0, 4'h3, 64'd0);
    exp_q.push_back({1'b1, 1'b0, 64'h333});
    #1;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("rblk_stall_%0d", c), {63'd0, pipe_stall}, 64'd0);
      check($sformatf("rblk_srcB_%0d", c), {60'd0, rf_srcB}, 64'h6);
      step();
    end
    check("rfrc_stall", {63'd0, pipe_stall}, 64'd1);
    check("rfrc_srcB", {60'd0, rf_srcB}, 64'h3);
    check("rfrc_dstE", {60'd0, rf_dstE}, 64'hF);
    step();
    host_drop();
    #1;
    check("rfrc_ack", {63'd0, host_ack}, 64'd1);
    step();
    w_idle();

    // host_reg = F: error ack, no regfile write
    host_issue(1'b1, 4'hF, 64'hBEEF);
    exp_q.push_back({1'b0, 1'b1, 64'd0});
    #1;
    check("err_dstE", {60'd0, rf_dstE}, 64'hF);
    check("err_dstM", {60'd0, rf_dstM}, 64'hF);
    check("err_stall", {63'd0, pipe_stall}, 64'd0);
    step();
    host_drop();
    #1;
    check("err_ack", {63'd0, host_ack}, 64'd1);
    step();
    check("err_rbx", regs[3], 64'h333);
    check("err_rbp", regs[5], 64'h55);

    // reset during a blocked host write
    W_dstE = 4'h1; W_valE = 64'h1;
    W_dstM = 4'h2; W_valM = 64'h2;
    host_issue(1'b1, 4'h6, 64'h66);
    step();
    step();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_stall", {63'd0, pipe_stall}, 64'd1);
    check("mid_rst_dstE", {60'd0, rf_dstE}, 64'hF);
    check("mid_rst_done", {63'd0, init_done}, 64'd0);
    step();
    w_idle();
    @(negedge clock);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rclr_dstE_%0d", i), {60'd0, rf_dstE}, 64'(i));
      step();
    end
    host_drop();
    for (int i = 5; i < 15; i++) begin
      check($sformatf("rclr_dstE_%0d", i), {60'd0, rf_dstE}, 64'(i));
      check($sformatf("rclr_done_%0d", i), {63'd0, init_done}, 64'd0);
      step();
    end
    check("rclr_done", {63'd0, init_done}, 64'd1);
    check("rclr_rsi", regs[6], 64'd0);
    check("rclr_rsp", regs[4], 64'h200);
    step();
    step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
